// File: rtl/cpu_reg_pkg.sv
// Shared types for the CPU register bank: op codes, default geometry, flag pair.
// Used by both the default build and the REG_BYPASS_EN build.
package cpu_reg_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREGS = 4;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_INC  = 3'b010,
    OP_DEC  = 3'b011,
    OP_CLR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef struct packed {
    logic z;
    logic c;
  } flags_t;

  function automatic logic op_is_active(op_e op);
    return !(op == OP_HOLD || op == OP_RSVD);
  endfunction

endpackage

// File: rtl/reg_op_unit.sv
// Combinational modify unit: computes the result and carry of one op on a register value.
// Shared by the write path and, in REG_BYPASS_EN builds, the read forwarding path.
module reg_op_unit
  import cpu_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             c_o,
  output logic             valid_op_o
);

  logic [WIDTH:0] ext_cur;
  assign ext_cur = {1'b0, cur_i};

  always_comb begin
    res_o      = cur_i;
    c_o        = 1'b0;
    valid_op_o = op_is_active(op_i);
    case (op_i)
      OP_LOAD: res_o = wr_data_i;
      // The extra top bit captures carry out / borrow from zero.
      OP_INC:  {c_o, res_o} = ext_cur + (WIDTH+1)'(1);
      OP_DEC:  {c_o, res_o} = ext_cur - (WIDTH+1)'(1);
      OP_CLR:  res_o = '0;
      OP_SHL:  {c_o, res_o} = {cur_i, 1'b0};
      OP_SHR:  {res_o, c_o} = {1'b0, cur_i};
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_reg_bank.sv
// Parametrised register bank: NREGS x WIDTH, one modify port, two combinational read ports.
// Define REG_BYPASS_EN to forward a same-cycle write result onto matching read ports.
module cpu_reg_bank
  import cpu_reg_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NREGS = DEF_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [2:0]       wr_op,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_a_addr,
  output logic [WIDTH-1:0] rd_a_data,
  input  logic [AW-1:0]    rd_b_addr,
  output logic [WIDTH-1:0] rd_b_data,
  output logic             flag_z,
  output logic             flag_c
);

  logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
  flags_t                      flags_q, flags_d;

  logic             wr_in_rng;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] res;
  logic             op_c;
  logic             valid_op;
  logic             wr_apply;

  assign wr_in_rng = 32'(wr_addr) < NREGS;
  assign cur       = wr_in_rng ? regs_q[wr_addr] : '0;

  reg_op_unit #(.WIDTH(WIDTH)) u_op (
    .cur_i      (cur),
    .wr_data_i  (wr_data),
    .op_i       (op_e'(wr_op)),
    .res_o      (res),
    .c_o        (op_c),
    .valid_op_o (valid_op)
  );

  // Out-of-range writes leave both the array and the flags untouched.
  assign wr_apply = we & valid_op & wr_in_rng;

  always_comb begin
    regs_d  = regs_q;
    flags_d = flags_q;
    if (wr_apply) begin
      regs_d[wr_addr] = res;
      flags_d.z       = (res == '0);
      flags_d.c       = op_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q  <= '0;
      flags_q <= '0;
    end else begin
      regs_q  <= regs_d;
      flags_q <= flags_d;
    end
  end

  assign flag_z = flags_q.z;
  assign flag_c = flags_q.c;

`ifdef REG_BYPASS_EN
  // No forwarding while reset is held: reads must show the cleared array.
  logic wr_fwd;
  assign wr_fwd = wr_apply & rst;
`endif

  logic [1:0][AW-1:0]    rd_addr;
  logic [1:0][WIDTH-1:0] rd_data;

  assign rd_addr   = {rd_b_addr, rd_a_addr};
  assign rd_a_data = rd_data[0];
  assign rd_b_data = rd_data[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic             in_rng;
    logic [WIDTH-1:0] arr_val;
    assign in_rng  = 32'(rd_addr[p]) < NREGS;
    assign arr_val = in_rng ? regs_q[rd_addr[p]] : '0;
`ifdef REG_BYPASS_EN
    assign rd_data[p] = (wr_fwd && rd_addr[p] == wr_addr) ? res : arr_val;
`else
    assign rd_data[p] = arr_val;
`endif
  end

endmodule

// File: tb/tb_cpu_reg_bank.sv
// Scoreboard bench for cpu_reg_bank: directed cycles push expectations, a negedge monitor checks them.
module tb_cpu_reg_bank;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, INC = 3'b010, DEC = 3'b011,
                         CLR  = 3'b100, SHL  = 3'b101, SHR = 3'b110, RSVD = 3'b111;
`ifdef REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [2:0] wr_op = HOLD;
  logic [7:0] wr_data = '0;
  logic [1:0] rd_a_addr = '0, rd_b_addr = '0;
  logic [7:0] rd_a_data, rd_b_data, rd3_a_data, rd3_b_data;
  logic       flag_z, flag_c, flag3_z, flag3_c;

  always #5 clk = ~clk;

  cpu_reg_bank #(.WIDTH(8), .NREGS(4)) dut (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_op(wr_op), .wr_data(wr_data),
    .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data), .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data),
    .flag_z(flag_z), .flag_c(flag_c)
  );

  // Three-register bank sharing the stimulus: address 3 is out of range here.
  cpu_reg_bank #(.WIDTH(8), .NREGS(3)) dut3 (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_op(wr_op), .wr_data(wr_data),
    .rd_a_addr(rd_a_addr), .rd_a_data(rd3_a_data), .rd_b_addr(rd_b_addr), .rd_b_data(rd3_b_data),
    .flag_z(flag3_z), .flag_c(flag3_c)
  );

  typedef struct {
    string      name;
    bit [3:0]   m;      // [0] port A, [1] port B, [2] flags, [3] 3-reg bank
    logic [7:0] a, b;
    logic       z, c;
    logic [7:0] a3;
    logic       z3, c3;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;

  function automatic void chk8(string n, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", n, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.m[0]) chk8({e.name, ".rd_a"}, rd_a_data, e.a);
      if (e.m[1]) chk8({e.name, ".rd_b"}, rd_b_data, e.b);
      if (e.m[2]) begin
        chk8({e.name, ".z"}, {7'b0, flag_z}, {7'b0, e.z});
        chk8({e.name, ".c"}, {7'b0, flag_c}, {7'b0, e.c});
      end
      if (e.m[3]) begin
        chk8({e.name, ".rd3_a"}, rd3_a_data, e.a3);
        chk8({e.name, ".z3"}, {7'b0, flag3_z}, {7'b0, e.z3});
        chk8({e.name, ".c3"}, {7'b0, flag3_c}, {7'b0, e.c3});
      end
    end
  end

  task automatic drive(input logic r, input logic w, input logic [1:0] ad, input logic [2:0] op,
                       input logic [7:0] d, input logic [1:0] ra, input logic [1:0] rb);
    @(posedge clk);
    #1;
    rst = r; we = w; wr_addr = ad; wr_op = op; wr_data = d; rd_a_addr = ra; rd_b_addr = rb;
  endtask

  task automatic cyc(input logic w, input logic [1:0] ad, input logic [2:0] op,
                     input logic [7:0] d, input logic [1:0] ra, input logic [1:0] rb);
    drive(1'b1, w, ad, op, d, ra, rb);
  endtask

  task automatic ex(input string n, input bit [3:0] m, input logic [7:0] a, input logic [7:0] b,
                    input logic z, input logic c,
                    input logic [7:0] a3 = 8'h00, input logic z3 = 1'b0, input logic c3 = 1'b0);
    exp_t t;
    t.name = n; t.m = m; t.a = a; t.b = b; t.z = z; t.c = c; t.a3 = a3; t.z3 = z3; t.c3 = c3;
    q.push_back(t);
  endtask

  initial begin
    // Reset state
    drive(1'b0, 0, 0, HOLD, 0, 0, 3); ex("rst_init", 4'b0111, 8'h00, 8'h00, 0, 0);

    // 1. Fill with A5, then pulse reset between edges
    for (int i = 0; i < 4; i++) cyc(1, 2'(i), LOAD, 8'hA5, 0, 0);
    cyc(0, 0, HOLD, 0, 0, 3);          ex("fill", 4'b0111, 8'hA5, 8'hA5, 0, 0);
    drive(1'b0, 0, 0, HOLD, 0, 1, 2);  ex("rst_pulse", 4'b0111, 8'h00, 8'h00, 0, 0);
    @(negedge clk); #1 rst = 1'b1;

    // 2. LOAD FF, INC wraps, DEC borrows
    cyc(1, 1, LOAD, 8'hFF, 1, 0); ex("ld_ff", 4'b0111, BYP ? 8'hFF : 8'h00, 8'h00, 0, 0);
    cyc(1, 1, INC,  8'h00, 1, 0); ex("inc_wrap", 4'b0101, BYP ? 8'h00 : 8'hFF, 8'h00, 0, 0);
    cyc(1, 1, DEC,  8'h00, 1, 0); ex("dec_ff", 4'b0101, BYP ? 8'hFF : 8'h00, 8'h00, 1, 1);
    cyc(0, 1, HOLD, 8'h00, 1, 0); ex("dec_res", 4'b0101, 8'hFF, 8'h00, 0, 1);

    // 3. Shifts and clear
    cyc(1, 2, LOAD, 8'h81, 2, 0); ex("ld_81", 4'b0101, BYP ? 8'h81 : 8'h00, 8'h00, 0, 1);
    cyc(1, 2, SHL,  8'h00, 2, 0); ex("shl", 4'b0101, BYP ? 8'h02 : 8'h81, 8'h00, 0, 0);
    cyc(1, 2, SHR,  8'h00, 2, 0); ex("shr", 4'b0101, BYP ? 8'h01 : 8'h02, 8'h00, 0, 1);
    cyc(1, 2, CLR,  8'h00, 2, 0); ex("clr", 4'b0101, BYP ? 8'h00 : 8'h01, 8'h00, 0, 0);
    cyc(0, 2, HOLD, 8'h00, 2, 0); ex("clr_res", 4'b0101, 8'h00, 8'h00, 1, 0);

    // 4. Disabled / reserved ops, out-of-range write and read on the 3-reg bank
    cyc(1, 3, LOAD, 8'h10, 3, 0); ex("ld_r3", 4'b1101, BYP ? 8'h10 : 8'h00, 8'h00, 1, 0, 8'h00, 1, 0);
    cyc(0, 3, INC,  8'h00, 3, 0); ex("we0", 4'b1101, 8'h10, 8'h00, 0, 0, 8'h00, 1, 0);
    cyc(1, 3, RSVD, 8'h00, 3, 0); ex("rsvd", 4'b1101, 8'h10, 8'h00, 0, 0, 8'h00, 1, 0);
    cyc(1, 3, HOLD, 8'h00, 3, 0); ex("hold", 4'b1101, 8'h10, 8'h00, 0, 0, 8'h00, 1, 0);
    cyc(0, 3, HOLD, 8'h00, 3, 0); ex("unchg", 4'b1101, 8'h10, 8'h00, 0, 0, 8'h00, 1, 0);

    // 5. Read during write
    cyc(1, 0, LOAD, 8'h05, 0, 1); ex("ld_05", 4'b0101, BYP ? 8'h05 : 8'h00, 8'h00, 0, 0);
    cyc(1, 0, INC,  8'h00, 0, 1); ex("rdw", 4'b0101, BYP ? 8'h06 : 8'h05, 8'h00, 0, 0);
    cyc(0, 0, HOLD, 8'h00, 0, 1); ex("rdw_res", 4'b0101, 8'h06, 8'h00, 0, 0);

    // 6. Chained INC with both ports on r2
    cyc(1, 2, CLR, 8'h00, 2, 2); ex("ch_clr", 4'b0111, 8'h00, 8'h00, 0, 0);
    cyc(1, 2, INC, 8'h00, 2, 2); ex("ch_inc1", 4'b0111, BYP ? 8'h01 : 8'h00, BYP ? 8'h01 : 8'h00, 1, 0);
    cyc(1, 2, INC, 8'h00, 2, 2); ex("ch_inc2", 4'b0111, BYP ? 8'h02 : 8'h01, BYP ? 8'h02 : 8'h01, 0, 0);
    cyc(1, 2, INC, 8'h00, 2, 2); ex("ch_inc3", 4'b0111, BYP ? 8'h03 : 8'h02, BYP ? 8'h03 : 8'h02, 0, 0);
    cyc(0, 2, HOLD, 8'h00, 2, 2); ex("ch_res", 4'b0111, 8'h03, 8'h03, 0, 0);

    // DEC from zero borrows
    cyc(1, 1, CLR,  8'h00, 1, 2); ex("b_clr", 4'b0111, BYP ? 8'h00 : 8'hFF, 8'h03, 0, 0);
    cyc(1, 1, DEC,  8'h00, 1, 2); ex("b_dec", 4'b0101, BYP ? 8'hFF : 8'h00, 8'h00, 1, 0);
    cyc(0, 1, HOLD, 8'h00, 1, 2); ex("b_res", 4'b0111, 8'hFF, 8'h03, 0, 1);

    // Reset held across an edge with a write pending
    drive(1'b0, 1, 2, INC, 8'h00, 2, 1); ex("rst_mid", 4'b0111, 8'h00, 8'h00, 0, 0);
    cyc(0, 2, HOLD, 8'h00, 2, 1);        ex("rst_mid_res", 4'b0111, 8'h00, 8'h00, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
